// File: rtl/byte_stream_deserialiser.sv
// Packs a valid/ready byte stream into OUT_BYTES-wide words with per-lane keep bits and last.
// Optional idle flush of partial words: define BYTE_STREAM_DESER_IDLE_FLUSH_EN.
module byte_stream_deserialiser #(
   parameter int unsigned OUT_BYTES    = 8,
   parameter int unsigned BIG_ENDIAN   = 1,
   parameter int unsigned IDLE_TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             s_data,
   input  logic                   s_valid,
   input  logic                   s_last,
   output logic                   s_ready,
   output logic [8*OUT_BYTES-1:0] m_data,
   output logic [OUT_BYTES-1:0]   m_keep,
   output logic                   m_valid,
   output logic                   m_last,
`ifdef BYTE_STREAM_DESER_IDLE_FLUSH_EN
   output logic                   m_flush,
`endif
   input  logic                   m_ready
);

   localparam int unsigned   DW       = 8 * OUT_BYTES;
   localparam int unsigned   CW       = $clog2(OUT_BYTES);
   localparam logic [CW-1:0] LAST_IDX = CW'(OUT_BYTES - 1);

   if (!(OUT_BYTES == 2 || OUT_BYTES == 4 || OUT_BYTES == 8) ||
       IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 65535) begin : g_bad_param
      $error("byte_stream_deserialiser: illegal parameter value");
   end

   typedef enum logic {FILL = 1'b0, STALL = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d, lane;
   logic [DW-1:0]        acc_data_q, acc_data_d, word_data, emit_data, m_data_d;
   logic [OUT_BYTES-1:0] acc_keep_q, acc_keep_d, word_keep, emit_keep, m_keep_d;
   logic                 acc_last_q, acc_last_d, emit_last, m_last_d;
   logic                 m_valid_d, s_ready_d;
   logic                 accept, out_free, complete, flush_hit;

   assign accept   = s_valid && s_ready;
   assign out_free = !m_valid || m_ready;

`ifdef BYTE_STREAM_DESER_IDLE_FLUSH_EN
   localparam logic [15:0] IDLE_THRESH = 16'(IDLE_TIMEOUT - 1);
   logic [15:0] idle_q, idle_d;
   logic        acc_flush_q, acc_flush_d, m_flush_d;

   // Idle counter: flush fires on the cycle the count would reach the threshold, unless a byte arrives.
   always_comb begin
      idle_d    = '0;
      flush_hit = 1'b0;
      if (state_q == FILL && cnt_q != '0 && !accept) begin
         if (idle_q == IDLE_THRESH) flush_hit = 1'b1;
         else                       idle_d    = idle_q + 16'd1;
      end
   end
`else
   assign flush_hit = 1'b0;
`endif

   // Accumulator contents with the incoming byte merged into its lane.
   always_comb begin
      lane      = (BIG_ENDIAN != 0) ? LAST_IDX - cnt_q : cnt_q;
      word_data = acc_data_q;
      word_keep = acc_keep_q;
      for (int unsigned i = 0; i < OUT_BYTES; i++) begin
         if (CW'(i) == lane) begin
            word_data[8*i +: 8] = s_data;
            word_keep[i]        = 1'b1;
         end
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_data_d = acc_data_q;
      acc_keep_d = acc_keep_q;
      acc_last_d = acc_last_q;
      m_data_d   = m_data;
      m_keep_d   = m_keep;
      m_last_d   = m_last;
      m_valid_d  = m_valid && !m_ready;
      complete   = 1'b0;
      emit_data  = acc_data_q;
      emit_keep  = acc_keep_q;
      emit_last  = 1'b0;
`ifdef BYTE_STREAM_DESER_IDLE_FLUSH_EN
      acc_flush_d = acc_flush_q;
      m_flush_d   = m_flush;
`endif
      case (state_q)
         FILL: begin
            if (accept) begin
               emit_data = word_data;
               emit_keep = word_keep;
               emit_last = s_last;
               complete  = (cnt_q == LAST_IDX) || s_last;
            end else begin
               complete  = flush_hit;
            end
            if (complete) begin
               cnt_d = '0;
               if (out_free) begin
                  m_valid_d  = 1'b1;
                  m_data_d   = emit_data;
                  m_keep_d   = emit_keep;
                  m_last_d   = emit_last;
                  acc_data_d = '0;
                  acc_keep_d = '0;
                  acc_last_d = 1'b0;
`ifdef BYTE_STREAM_DESER_IDLE_FLUSH_EN
                  m_flush_d   = flush_hit;
                  acc_flush_d = 1'b0;
`endif
               end else begin
                  acc_data_d = emit_data;
                  acc_keep_d = emit_keep;
                  acc_last_d = emit_last;
                  state_d    = STALL;
`ifdef BYTE_STREAM_DESER_IDLE_FLUSH_EN
                  acc_flush_d = flush_hit;
`endif
               end
            end else if (accept) begin
               cnt_d      = cnt_q + CW'(1);
               acc_data_d = word_data;
               acc_keep_d = word_keep;
            end
         end
         STALL: begin
            if (m_valid && m_ready) begin
               m_valid_d  = 1'b1;
               m_data_d   = acc_data_q;
               m_keep_d   = acc_keep_q;
               m_last_d   = acc_last_q;
               acc_data_d = '0;
               acc_keep_d = '0;
               acc_last_d = 1'b0;
               state_d    = FILL;
`ifdef BYTE_STREAM_DESER_IDLE_FLUSH_EN
               m_flush_d   = acc_flush_q;
               acc_flush_d = 1'b0;
`endif
            end
         end
      endcase
      s_ready_d = (state_d == FILL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FILL;
      else        state_q <= state_d;
   end

   // s_ready is held low through reset and rises on the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ready    <= 1'b0;
         cnt_q      <= '0;
         acc_data_q <= '0;
         acc_keep_q <= '0;
         acc_last_q <= 1'b0;
         m_data     <= '0;
         m_keep     <= '0;
         m_last     <= 1'b0;
         m_valid    <= 1'b0;
`ifdef BYTE_STREAM_DESER_IDLE_FLUSH_EN
         idle_q      <= '0;
         acc_flush_q <= 1'b0;
         m_flush     <= 1'b0;
`endif
      end else begin
         s_ready    <= s_ready_d;
         cnt_q      <= cnt_d;
         acc_data_q <= acc_data_d;
         acc_keep_q <= acc_keep_d;
         acc_last_q <= acc_last_d;
         m_data     <= m_data_d;
         m_keep     <= m_keep_d;
         m_last     <= m_last_d;
         m_valid    <= m_valid_d;
`ifdef BYTE_STREAM_DESER_IDLE_FLUSH_EN
         idle_q      <= idle_d;
         acc_flush_q <= acc_flush_d;
         m_flush     <= m_flush_d;
`endif
      end
   end

endmodule

// File: tb/tb_byte_stream_deserialiser.sv
// Bench for byte_stream_deserialiser: big- and little-endian instances share one byte stream.
module tb_byte_stream_deserialiser;

   localparam int unsigned NB = 8;
   localparam int unsigned DW = 8 * NB;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_last = 1'b0;
   logic          m_ready = 1'b1;
   logic          s_ready_be, s_ready_le;
   logic [DW-1:0] m_data_be, m_data_le;
   logic [NB-1:0] m_keep_be, m_keep_le;
   logic          m_valid_be, m_valid_le, m_last_be, m_last_le;
`ifdef BYTE_STREAM_DESER_IDLE_FLUSH_EN
   logic          m_flush_be, m_flush_le;
`endif

   int   vectors = 0;
   int   errors  = 0;
   logic rand_ready_en = 1'b0;

   // Word records are {last, keep, data}.
   logic [DW+NB:0] obs_be[$], obs_le[$], exp_be[$], exp_le[$];

   always #5 clk = ~clk;

   byte_stream_deserialiser #(.OUT_BYTES(NB), .BIG_ENDIAN(1), .IDLE_TIMEOUT(4)) dut_be (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready_be), .m_data(m_data_be), .m_keep(m_keep_be), .m_valid(m_valid_be),
      .m_last(m_last_be),
`ifdef BYTE_STREAM_DESER_IDLE_FLUSH_EN
      .m_flush(m_flush_be),
`endif
      .m_ready(m_ready));

   byte_stream_deserialiser #(.OUT_BYTES(NB), .BIG_ENDIAN(0), .IDLE_TIMEOUT(4)) dut_le (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready_le), .m_data(m_data_le), .m_keep(m_keep_le), .m_valid(m_valid_le),
      .m_last(m_last_le),
`ifdef BYTE_STREAM_DESER_IDLE_FLUSH_EN
      .m_flush(m_flush_le),
`endif
      .m_ready(m_ready));

   // Record every word handed over; the handshake completes at the following rising edge.
   always @(negedge clk) begin
      if (rst_n && m_ready) begin
         if (m_valid_be) obs_be.push_back({m_last_be, m_keep_be, m_data_be});
         if (m_valid_le) obs_le.push_back({m_last_le, m_keep_le, m_data_le});
      end
   end

   always @(posedge clk) begin
      if (rand_ready_en) begin
         #1;
         m_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Reference word built arithmetically from the bytes of one chunk.
   function automatic logic [DW+NB:0] model_word(input logic [7:0] b[$], input bit be, input bit last);
      logic [DW-1:0] d;
      logic [NB-1:0] k;
      int            n;
      n = b.size();
      d = '0;
      k = NB'((1 << n) - 1);
      if (be) begin
         foreach (b[j]) d = (d << 8) | DW'(b[j]);
         d = d << (8 * (NB - n));
         k = k << (NB - n);
      end else begin
         foreach (b[j]) d = d | (DW'(b[j]) << (8 * j));
      end
      return {last, k, d};
   endfunction

   task automatic add_packet(input logic [7:0] pkt[$]);
      logic [7:0] chunk[$];
      for (int i = 0; i < pkt.size(); i++) begin
         chunk.push_back(pkt[i]);
         if (chunk.size() == NB || i == pkt.size() - 1) begin
            exp_be.push_back(model_word(chunk, 1'b1, i == pkt.size() - 1));
            exp_le.push_back(model_word(chunk, 1'b0, i == pkt.size() - 1));
            chunk.delete();
         end
      end
   endtask

   // Present one byte and return 1 ns after the edge that accepts it.
   task automatic send_byte(input logic [7:0] d, input logic last);
      int waited;
      waited  = 0;
      s_data  = d;
      s_last  = last;
      s_valid = 1'b1;
      @(negedge clk);
      while (!s_ready_be && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      if (!s_ready_be) begin
         vectors++;
         errors++;
         $display("FAIL send_timeout: s_ready=%0b after %0d cycles, required 1", s_ready_be, waited);
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      vectors++;
      if ({s_ready_be, m_valid_be, m_last_be, m_keep_be, m_data_be,
           s_ready_le, m_valid_le, m_last_le, m_keep_le, m_data_le} !== '0) begin
         errors++;
         $display("FAIL reset_values: got be=%b_%b_%b_%h_%h le=%b_%b_%b_%h_%h, required all zero",
                  s_ready_be, m_valid_be, m_last_be, m_keep_be, m_data_be,
                  s_ready_le, m_valid_le, m_last_le, m_keep_le, m_data_le);
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      vectors++;
      if ({s_ready_be, s_ready_le, m_valid_be} !== 3'b110) begin
         errors++;
         $display("FAIL reset_release: got s_ready=%b%b m_valid=%b, required s_ready=11 m_valid=0",
                  s_ready_be, s_ready_le, m_valid_be);
      end
   endtask

   task automatic test_big_endian();
      m_ready = 1'b1;
      for (int i = 1; i <= 7; i++) send_byte(8'(i), 1'b0);
      vectors++;
      if (m_valid_be !== 1'b0) begin
         errors++;
         $display("FAIL be_early: got m_valid=%b, required 0", m_valid_be);
      end
      send_byte(8'h08, 1'b1);
      vectors++;
      if ({m_valid_be, m_last_be, m_keep_be, m_data_be} !== {2'b11, 8'hFF, 64'h0102030405060708}) begin
         errors++;
         $display("FAIL be_word: got v=%b l=%b k=%h d=%h, required v=1 l=1 k=ff d=0102030405060708",
                  m_valid_be, m_last_be, m_keep_be, m_data_be);
      end
      vectors++;
      if ({m_valid_le, m_last_le, m_keep_le, m_data_le} !== {2'b11, 8'hFF, 64'h0807060504030201}) begin
         errors++;
         $display("FAIL le_full_word: got v=%b l=%b k=%h d=%h, required v=1 l=1 k=ff d=0807060504030201",
                  m_valid_le, m_last_le, m_keep_le, m_data_le);
      end
      tick();
      vectors++;
      if (m_valid_be !== 1'b0) begin
         errors++;
         $display("FAIL be_one_cycle: got m_valid=%b one cycle later, required 0", m_valid_be);
      end
   endtask

   task automatic test_little_endian();
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      send_byte(8'hCC, 1'b1);
      vectors++;
      if ({m_valid_le, m_last_le, m_keep_le, m_data_le} !== {2'b11, 8'h07, 64'h0000000000CCBBAA}) begin
         errors++;
         $display("FAIL le_partial: got v=%b l=%b k=%h d=%h, required v=1 l=1 k=07 d=0000000000ccbbaa",
                  m_valid_le, m_last_le, m_keep_le, m_data_le);
      end
      vectors++;
      if ({m_valid_be, m_last_be, m_keep_be, m_data_be} !== {2'b11, 8'hE0, 64'hAABBCC0000000000}) begin
         errors++;
         $display("FAIL be_partial: got v=%b l=%b k=%h d=%h, required v=1 l=1 k=e0 d=aabbcc0000000000",
                  m_valid_be, m_last_be, m_keep_be, m_data_be);
      end
      tick();
   endtask

   task automatic test_single_byte();
      send_byte(8'h5A, 1'b1);
      vectors++;
      if ({m_valid_be, m_last_be, m_keep_be, m_data_be, m_keep_le, m_data_le} !==
          {2'b11, 8'h80, 64'h5A00000000000000, 8'h01, 64'h000000000000005A}) begin
         errors++;
         $display("FAIL single_byte: got be k=%h d=%h l=%b le k=%h d=%h, required be k=80 d=5a00000000000000 l=1 le k=01 d=5a",
                  m_keep_be, m_data_be, m_last_be, m_keep_le, m_data_le);
      end
      send_byte(8'h77, 1'b0);
      send_byte(8'h66, 1'b1);
      vectors++;
      if ({m_valid_be, m_last_be, m_keep_be, m_data_be} !== {2'b11, 8'hC0, 64'h7766000000000000}) begin
         errors++;
         $display("FAIL next_packet_lane7: got v=%b l=%b k=%h d=%h, required v=1 l=1 k=c0 d=7766000000000000",
                  m_valid_be, m_last_be, m_keep_be, m_data_be);
      end
      tick();
   endtask

   task automatic test_back_to_back_stall();
      m_ready = 1'b0;
      for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
      for (int r = 0; r < 4; r++) begin
         vectors++;
         if ({s_ready_be, m_valid_be, m_last_be, m_keep_be, m_data_be, m_data_le} !==
             {3'b010, 8'hFF, 64'h0001020304050607, 64'h0706050403020100}) begin
            errors++;
            $display("FAIL stall_hold_%0d: got s_ready=%b v=%b l=%b k=%h be=%h le=%h, required s_ready=0 v=1 l=0 k=ff be=0001020304050607 le=0706050403020100",
                     r, s_ready_be, m_valid_be, m_last_be, m_keep_be, m_data_be, m_data_le);
         end
         tick();
      end
      m_ready = 1'b1;
      tick();
      vectors++;
      if ({s_ready_be, m_valid_be, m_last_be, m_keep_be, m_data_be, m_data_le} !==
          {3'b110, 8'hFF, 64'h08090A0B0C0D0E0F, 64'h0F0E0D0C0B0A0908}) begin
         errors++;
         $display("FAIL stall_second: got s_ready=%b v=%b l=%b k=%h be=%h le=%h, required s_ready=1 v=1 l=0 k=ff be=08090a0b0c0d0e0f le=0f0e0d0c0b0a0908",
                  s_ready_be, m_valid_be, m_last_be, m_keep_be, m_data_be, m_data_le);
      end
      tick();
      vectors++;
      if (m_valid_be !== 1'b0) begin
         errors++;
         $display("FAIL stall_drain: got m_valid=%b, required 0", m_valid_be);
      end
   endtask

   task automatic test_reset_mid_packet();
      logic [7:0] fresh[$];
      logic [DW+NB:0] want;
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i), 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      vectors++;
      if ({m_valid_be, m_valid_le, s_ready_be} !== 3'b001) begin
         errors++;
         $display("FAIL reset_mid_release: got v=%b%b s_ready=%b, required v=00 s_ready=1",
                  m_valid_be, m_valid_le, s_ready_be);
      end
      obs_be.delete();
      obs_le.delete();
      for (int i = 0; i < NB; i++) fresh.push_back(8'($urandom));
      want = model_word(fresh, 1'b1, 1'b1);
      for (int i = 0; i < NB; i++) send_byte(fresh[i], i == NB - 1);
      repeat (4) tick();
      vectors++;
      if (obs_be.size() != 1) begin
         errors++;
         $display("FAIL reset_mid_count: got %0d words, required 1", obs_be.size());
      end else if (obs_be[0] !== want) begin
         errors++;
         $display("FAIL reset_mid_word: got %h, required %h", obs_be[0], want);
      end
   endtask

`ifdef BYTE_STREAM_DESER_IDLE_FLUSH_EN
   task automatic test_idle_flush();
      m_ready = 1'b1;
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      repeat (3) tick();
      vectors++;
      if (m_valid_be !== 1'b0) begin
         errors++;
         $display("FAIL flush_early: got m_valid=%b after 3 idle cycles, required 0", m_valid_be);
      end
      tick();
      vectors++;
      if ({m_valid_be, m_last_be, m_flush_be, m_keep_be, m_data_be, m_flush_le, m_keep_le, m_data_le} !==
          {3'b101, 8'hC0, 64'h1122000000000000, 1'b1, 8'h03, 64'h0000000000002211}) begin
         errors++;
         $display("FAIL flush_word: got v=%b l=%b f=%b k=%h d=%h le f=%b k=%h d=%h, required v=1 l=0 f=1 k=c0 d=1122000000000000 le f=1 k=03 d=2211",
                  m_valid_be, m_last_be, m_flush_be, m_keep_be, m_data_be, m_flush_le, m_keep_le, m_data_le);
      end
      tick();
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b0);
      repeat (3) tick();
      send_byte(8'h55, 1'b0);
      vectors++;
      if (m_valid_be !== 1'b0) begin
         errors++;
         $display("FAIL flush_byte_wins: got m_valid=%b, required 0", m_valid_be);
      end
      repeat (3) tick();
      vectors++;
      if (m_valid_be !== 1'b0) begin
         errors++;
         $display("FAIL flush_restart_early: got m_valid=%b, required 0", m_valid_be);
      end
      tick();
      vectors++;
      if ({m_valid_be, m_last_be, m_flush_be, m_keep_be, m_data_be, m_keep_le, m_data_le} !==
          {3'b101, 8'hE0, 64'h3344550000000000, 8'h07, 64'h0000000000554433}) begin
         errors++;
         $display("FAIL flush_word2: got v=%b l=%b f=%b k=%h d=%h le k=%h d=%h, required v=1 l=0 f=1 k=e0 d=3344550000000000 le k=07 d=554433",
                  m_valid_be, m_last_be, m_flush_be, m_keep_be, m_data_be, m_keep_le, m_data_le);
      end
      tick();
   endtask
`else
   task automatic test_idle_hold();
      m_ready = 1'b1;
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      repeat (40) tick();
      vectors++;
      if (m_valid_be !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_word: got m_valid=%b after long idle, required 0", m_valid_be);
      end
      send_byte(8'h33, 1'b1);
      vectors++;
      if ({m_valid_be, m_last_be, m_keep_be, m_data_be, m_keep_le, m_data_le} !==
          {2'b11, 8'hE0, 64'h1122330000000000, 8'h07, 64'h0000000000332211}) begin
         errors++;
         $display("FAIL idle_resume: got v=%b l=%b k=%h d=%h le k=%h d=%h, required v=1 l=1 k=e0 d=1122330000000000 le k=07 d=332211",
                  m_valid_be, m_last_be, m_keep_be, m_data_be, m_keep_le, m_data_le);
      end
      tick();
   endtask
`endif

   task automatic test_random_stream();
      logic [7:0] pkt[$];
      int         len;
      obs_be.delete();
      obs_le.delete();
      exp_be.delete();
      exp_le.delete();
      rand_ready_en = 1'b1;
      for (int p = 0; p < 30; p++) begin
         pkt.delete();
         len = $urandom_range(1, 20);
         for (int j = 0; j < len; j++) pkt.push_back(8'($urandom));
         add_packet(pkt);
         for (int j = 0; j < len; j++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_byte(pkt[j], j == len - 1);
         end
      end
      for (int c = 0; c < 2000 && obs_le.size() < exp_le.size(); c++) @(posedge clk);
      repeat (5) @(posedge clk);
      #2 rand_ready_en = 1'b0;
      @(posedge clk);
      #2 m_ready = 1'b1;
      vectors++;
      if (obs_be.size() != exp_be.size() || obs_le.size() != exp_le.size()) begin
         errors++;
         $display("FAIL random_count: got be=%0d le=%0d words, required %0d",
                  obs_be.size(), obs_le.size(), exp_be.size());
      end
      for (int i = 0; i < exp_be.size() && i < obs_be.size() && i < obs_le.size(); i++) begin
         vectors++;
         if (obs_be[i] !== exp_be[i] || obs_le[i] !== exp_le[i]) begin
            errors++;
            $display("FAIL random_word_%0d: got be=%h le=%h, required be=%h le=%h",
                     i, obs_be[i], obs_le[i], exp_be[i], exp_le[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_big_endian();
      test_little_endian();
      test_single_byte();
      test_back_to_back_stall();
      test_reset_mid_packet();
`ifdef BYTE_STREAM_DESER_IDLE_FLUSH_EN
      test_idle_flush();
`else
      test_idle_hold();
`endif
      test_random_stream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
